control_unit: RTL and testbench
===============================

CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have ports: clock  in  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have ports: reset  in  1  synchronous, active-high.
REQ-003 SHALL have ports: instr  in  16  fetched word (memval); latched into IR during FETCH.
REQ-004 SHALL have ports: mem_ready  in  1  memory handshake complete.
REQ-005 SHALL have ports: overflow  in  1  ALU overflow from datapath.
REQ-006 SHALL have ports: comp_nz  in  1  comp register non-zero.
REQ-007 SHALL have ports: mem_req  out  1, mem_we  out  1, addr_src  out  1 (0 = pc, 1 = aluout).
REQ-008 SHALL have ports: mary_write, shelley_write, comp_write, ra_write  out  1 each; mary_src, shelley_src  out  2; ra_src  out  1.
REQ-009 SHALL have ports: SrcA  out  1; SrcB  out  2; AluOp  out  4; immediate  out  8 (IR[7:0]).
REQ-010 SHALL have ports: pc_write  out  1; pc_src  out  2; trap  out  1 (sticky); halted  out  1.

Function
REQ-011 SHALL decode IR as: opcode IR[15:12]; dest IR[11:10] (00 mary, 01 shelley, 10 comp, 11 ra); SrcB IR[9:8]; imm IR[7:0].
REQ-012 SHALL use these opcode classes: 0x0-0x7 ALU (AluOp = opcode); 0x8 LOAD; 0x9 STORE; 0xA BNZ; 0xB JAL; 0xC LI; 0xF HALT; 0xD/0xE illegal.
REQ-013 SHALL implement states FETCH, DECODE, EXEC, MEM, WB, HALT, encoded in 3 bits.
REQ-014 FETCH SHALL drive mem_req=1, addr_src=0, and stay in FETCH until mem_ready; on mem_ready it latches IR, pulses pc_write with pc_src=00 (pc+2), and goes to DECODE.
REQ-015 DECODE SHALL last 1 cycle with no writes, then go to EXEC; illegal opcodes go to HALT with trap=1.
REQ-016 ALU EXEC SHALL drive SrcA=0, SrcB=IR[9:8], and AluOp, then go to WB.
REQ-017 If overflow=1 in an ALU EXEC, WB SHALL be skipped (no register write), trap SHALL be set, and the FSM goes to HALT.
REQ-018 WB SHALL pulse exactly one *_write selected by dest, with src 01 (aluout) for ALU and 00 (memval) for LOAD, then go to FETCH.
REQ-019 LOAD/STORE EXEC SHALL compute the address with SrcA=1 (sp), SrcB=11 (sext_ls_imm), AluOp=0x0, then go to MEM.
REQ-020 MEM SHALL hold mem_req=1 and addr_src=1 (mem_we=1 for STORE) until mem_ready; LOAD then goes to WB, STORE to FETCH.
REQ-021 BNZ EXEC SHALL pulse pc_write with pc_src=01 (pc + sext_ls_imm) only if comp_nz=1, then go to FETCH.
REQ-022 JAL EXEC SHALL pulse ra_write with ra_src=0 (pc) and pc_write with pc_src=01 in the same cycle, then go to FETCH.
REQ-023 LI EXEC SHALL pulse the dest write with src=10 (sext imm), then go to FETCH; dest=10 (comp) is a no-op.
REQ-024 HALT SHALL be absorbing: halted=1, all strobes 0, until reset.
REQ-025 Minimum latencies SHALL be: ALU/LOAD 4/5 cycles; STORE 4; BNZ/JAL/LI/HALT 3; each mem_ready stall adds 1 cycle.
REQ-026 All strobes SHALL be Moore outputs except pc_write in FETCH, which is gated by mem_ready.

Reset
REQ-027 On reset the FSM SHALL go to FETCH, clear IR to 0, clear trap and halted, and drive all strobes 0; reset takes priority over mem_ready.
REQ-028 A reset during a MEM stall SHALL abandon the access: mem_req=0 on the next cycle, with no register or pc write.

Structure
REQ-029 Opcode constants, the state encoding, and the src/SrcB/pc_src encodings SHALL live in a shared package reused by the datapath.
REQ-030 Decode SHALL be a combinational sub-module, instr_decoder (IR -> class, dest, fields); the FSM and IR stay in control_unit.

Verification
REQ-031 ALU: IR=0x0100 (add, dest mary, SrcB shelley), mem_ready tied 1 -> mary_write pulses in cycle 4 with mary_src=01, and FETCH re-asserts in cycle 5.
REQ-032 LOAD: IR=0x84FE with mem_ready delayed 3 cycles in MEM -> SrcA=1, SrcB=11 in EXEC; shelley_write asserts once, after the stall.
REQ-033 BNZ: IR=0xA004 with comp_nz=0, then comp_nz=1 -> pc_write in EXEC absent, then present with pc_src=01.
REQ-034 Overflow: add with overflow=1 in EXEC -> no write; trap=1 and halted=1 from the next cycle, held until reset.
REQ-035 Reset mid-MEM of a STORE -> mem_req and mem_we drop next cycle; FSM is in FETCH and trap=0.
REQ-036 Illegal opcode 0xD000 -> HALT after DECODE, trap=1, no strobes.

Source files
------------

// File: rtl/control_unit_pkg.sv
// Shared encodings for the control unit and the datapath it steers:
// opcodes, FSM states, instruction classes and mux select codes.
package control_unit_pkg;

  localparam logic [3:0] OP_ALU_LAST = 4'h7;
  localparam logic [3:0] OP_LOAD     = 4'h8;
  localparam logic [3:0] OP_STORE    = 4'h9;
  localparam logic [3:0] OP_BNZ      = 4'hA;
  localparam logic [3:0] OP_JAL      = 4'hB;
  localparam logic [3:0] OP_LI       = 4'hC;
  localparam logic [3:0] OP_HALT     = 4'hF;

  localparam logic [3:0] ALU_OP_ADD  = 4'h0;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    CLS_ALU, CLS_LOAD, CLS_STORE, CLS_BNZ, CLS_JAL, CLS_LI, CLS_HALT, CLS_ILLEGAL
  } instr_class_e;

  typedef enum logic [1:0] {
    DEST_MARY    = 2'b00,
    DEST_SHELLEY = 2'b01,
    DEST_COMP    = 2'b10,
    DEST_RA      = 2'b11
  } dest_e;

  // Register write-data select (mary_src / shelley_src)
  localparam logic [1:0] SRC_MEMVAL   = 2'b00;
  localparam logic [1:0] SRC_ALUOUT   = 2'b01;
  localparam logic [1:0] SRC_SEXT_IMM = 2'b10;

  // ra has a 1-bit select: link pc, or the shared writeback bus
  localparam logic RA_SRC_PC = 1'b0;
  localparam logic RA_SRC_WB = 1'b1;

  localparam logic SRCA_REG = 1'b0;
  localparam logic SRCA_SP  = 1'b1;

  localparam logic [1:0] SRCB_SEXT_LS_IMM = 2'b11;

  localparam logic [1:0] PC_SRC_INC = 2'b00;
  localparam logic [1:0] PC_SRC_REL = 2'b01;

  localparam logic ADDR_SRC_PC     = 1'b0;
  localparam logic ADDR_SRC_ALUOUT = 1'b1;

endpackage

// File: rtl/control_unit_decoder.sv
// Combinational instruction decoder: splits the latched IR into class,
// destination and operand fields.
module instr_decoder
  import control_unit_pkg::*;
(
  input  logic [15:0]  ir,
  output instr_class_e cls,
  output dest_e        dest,
  output logic [3:0]   alu_op,
  output logic [1:0]   srcb,
  output logic [7:0]   imm
);

  logic [3:0] opcode;

  assign opcode = ir[15:12];
  assign dest   = dest_e'(ir[11:10]);
  assign srcb   = ir[9:8];
  assign imm    = ir[7:0];
  assign alu_op = opcode;

  always_comb begin
    cls = CLS_ILLEGAL;
    if (opcode <= OP_ALU_LAST) begin
      cls = CLS_ALU;
    end else begin
      case (opcode)
        OP_LOAD:  cls = CLS_LOAD;
        OP_STORE: cls = CLS_STORE;
        OP_BNZ:   cls = CLS_BNZ;
        OP_JAL:   cls = CLS_JAL;
        OP_LI:    cls = CLS_LI;
        OP_HALT:  cls = CLS_HALT;
        default:  cls = CLS_ILLEGAL;
      endcase
    end
  end

endmodule

// File: rtl/control_unit.sv
// Multicycle control FSM: fetch/decode/exec/mem/writeback sequencing,
// instruction register and sticky trap flag.
module control_unit
  import control_unit_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] instr,
  input  logic        mem_ready,
  input  logic        overflow,
  input  logic        comp_nz,
  output logic        mem_req,
  output logic        mem_we,
  output logic        addr_src,
  output logic        mary_write,
  output logic        shelley_write,
  output logic        comp_write,
  output logic        ra_write,
  output logic [1:0]  mary_src,
  output logic [1:0]  shelley_src,
  output logic        ra_src,
  output logic        SrcA,
  output logic [1:0]  SrcB,
  output logic [3:0]  AluOp,
  output logic [7:0]  immediate,
  output logic        pc_write,
  output logic [1:0]  pc_src,
  output logic        trap,
  output logic        halted
);

  state_e       state, next_state;
  logic [15:0]  ir;
  logic         ir_load, trap_set;
  logic         reg_we, jal_link;
  logic [1:0]   reg_src;
  instr_class_e cls;
  dest_e        dest;
  logic [3:0]   alu_op;
  logic [1:0]   ir_srcb;
  logic [7:0]   ir_imm;

  instr_decoder u_decoder (
    .ir     (ir),
    .cls    (cls),
    .dest   (dest),
    .alu_op (alu_op),
    .srcb   (ir_srcb),
    .imm    (ir_imm)
  );

  assign immediate = ir_imm;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_FETCH;
      ir    <= '0;
      trap  <= 1'b0;
    end else begin
      state <= next_state;
      if (ir_load)  ir   <= instr;
      if (trap_set) trap <= 1'b1;
    end
  end

  always_comb begin
    next_state = state;
    ir_load    = 1'b0;
    trap_set   = 1'b0;
    reg_we     = 1'b0;
    reg_src    = SRC_MEMVAL;
    jal_link   = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    addr_src   = ADDR_SRC_PC;
    pc_write   = 1'b0;
    pc_src     = PC_SRC_INC;
    SrcA       = SRCA_REG;
    SrcB       = '0;
    AluOp      = '0;
    halted     = 1'b0;

    case (state)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_load    = 1'b1;
          pc_write   = 1'b1;
          next_state = S_DECODE;
        end
      end
      S_DECODE: begin
        if (cls == CLS_ILLEGAL) begin
          trap_set   = 1'b1;
          next_state = S_HALT;
        end else begin
          next_state = S_EXEC;
        end
      end
      S_EXEC: begin
        next_state = S_FETCH;
        case (cls)
          CLS_ALU: begin
            SrcB  = ir_srcb;
            AluOp = alu_op;
            if (overflow) begin
              trap_set   = 1'b1;
              next_state = S_HALT;
            end else begin
              next_state = S_WB;
            end
          end
          CLS_LOAD, CLS_STORE: begin
            SrcA       = SRCA_SP;
            SrcB       = SRCB_SEXT_LS_IMM;
            AluOp      = ALU_OP_ADD;
            next_state = S_MEM;
          end
          CLS_BNZ: begin
            pc_write = comp_nz;
            pc_src   = PC_SRC_REL;
          end
          CLS_JAL: begin
            jal_link = 1'b1;
            pc_write = 1'b1;
            pc_src   = PC_SRC_REL;
          end
          CLS_LI: begin
            reg_we  = (dest != DEST_COMP);
            reg_src = SRC_SEXT_IMM;
          end
          CLS_HALT: next_state = S_HALT;
          default: begin
            trap_set   = 1'b1;
            next_state = S_HALT;
          end
        endcase
      end
      S_MEM: begin
        mem_req  = 1'b1;
        addr_src = ADDR_SRC_ALUOUT;
        mem_we   = (cls == CLS_STORE);
        if (mem_ready) next_state = (cls == CLS_LOAD) ? S_WB : S_FETCH;
      end
      S_WB: begin
        reg_we     = 1'b1;
        reg_src    = (cls == CLS_ALU) ? SRC_ALUOUT : SRC_MEMVAL;
        next_state = S_FETCH;
      end
      S_HALT: halted = 1'b1;
      default: next_state = S_FETCH;
    endcase

    mary_write    = reg_we && (dest == DEST_MARY);
    shelley_write = reg_we && (dest == DEST_SHELLEY);
    comp_write    = reg_we && (dest == DEST_COMP);
    ra_write      = jal_link || (reg_we && (dest == DEST_RA));
    mary_src      = mary_write ? reg_src : SRC_MEMVAL;
    shelley_src   = shelley_write ? reg_src : SRC_MEMVAL;
    ra_src        = (reg_we && (dest == DEST_RA)) ? RA_SRC_WB : RA_SRC_PC;

    // Reset masks everything combinationally so an in-flight access or a
    // ready fetch is abandoned in the same cycle reset is seen.
    if (reset) begin
      next_state    = S_FETCH;
      ir_load       = 1'b0;
      trap_set      = 1'b0;
      mem_req       = 1'b0;
      mem_we        = 1'b0;
      addr_src      = ADDR_SRC_PC;
      pc_write      = 1'b0;
      pc_src        = PC_SRC_INC;
      mary_write    = 1'b0;
      shelley_write = 1'b0;
      comp_write    = 1'b0;
      ra_write      = 1'b0;
      mary_src      = SRC_MEMVAL;
      shelley_src   = SRC_MEMVAL;
      ra_src        = RA_SRC_PC;
      SrcA          = SRCA_REG;
      SrcB          = '0;
      AluOp         = '0;
      halted        = 1'b0;
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: per-instruction expectations are
// derived from the instruction-class latency and side-effect rules.
module tb_control_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] instr = '0;
  logic        mem_ready = 1'b0;
  logic        overflow = 1'b0;
  logic        comp_nz = 1'b0;
  logic        mem_req, mem_we, addr_src;
  logic        mary_write, shelley_write, comp_write, ra_write;
  logic [1:0]  mary_src, shelley_src;
  logic        ra_src, SrcA;
  logic [1:0]  SrcB;
  logic [3:0]  AluOp;
  logic [7:0]  immediate;
  logic        pc_write;
  logic [1:0]  pc_src;
  logic        trap, halted;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  control_unit dut (
    .clock(clock), .reset(reset), .instr(instr), .mem_ready(mem_ready),
    .overflow(overflow), .comp_nz(comp_nz), .mem_req(mem_req), .mem_we(mem_we),
    .addr_src(addr_src), .mary_write(mary_write), .shelley_write(shelley_write),
    .comp_write(comp_write), .ra_write(ra_write), .mary_src(mary_src),
    .shelley_src(shelley_src), .ra_src(ra_src), .SrcA(SrcA), .SrcB(SrcB),
    .AluOp(AluOp), .immediate(immediate), .pc_write(pc_write), .pc_src(pc_src),
    .trap(trap), .halted(halted)
  );

  function automatic logic any_strobe();
    return mem_req | mem_we | mary_write | shelley_write | comp_write | ra_write | pc_write;
  endfunction

  task automatic test_reset();
    @(negedge clock);
    reset = 1'b1; mem_ready = 1'b1; instr = 16'($urandom);
    #1;
    checks++;
    if (any_strobe() !== 1'b0) begin
      errors++; $display("FAIL reset_assert: strobes active=%b, required 0", any_strobe());
    end
    @(negedge clock);
    #1;
    checks++;
    if (any_strobe() !== 1'b0 || trap !== 1'b0 || halted !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: strobes=%b trap=%b halted=%b, required 0 0 0", any_strobe(), trap, halted);
    end
    @(posedge clock);
    #1;
    reset = 1'b0; mem_ready = 1'b0;
  endtask

  // Runs one instruction from its first FETCH cycle; fs = fetch stall cycles,
  // ms = MEM stall cycles. Returns whether the instruction should halt.
  task automatic run_one(input logic [15:0] word, input int fs, input int ms,
                         input logic ovf, input logic cnz, output bit exp_halt);
    int op, dst, len, exp_wr, exp_wc, exp_pcw, exp_mreq, exp_mwe;
    int n_mreq, n_mwe, n_pcw, n_wr, n_halt, bad_addr, bad_pcsrc, wr_idx, wr_cyc;
    bit is_alu, is_ld, is_st, is_bnz, is_jal, is_li, is_hlt, is_ill, exp_trap;
    logic [1:0] exp_src, wr_src, exp_b;
    logic [3:0] wr, exp_op;
    logic exp_a;

    op = int'(word[15:12]); dst = int'(word[11:10]);
    is_alu = (op < 8); is_ld = (op == 8); is_st = (op == 9); is_bnz = (op == 10);
    is_jal = (op == 11); is_li = (op == 12); is_hlt = (op == 15); is_ill = (op == 13 || op == 14);

    exp_halt = 0; exp_trap = 0; exp_wr = -1; exp_wc = -1; exp_src = 2'b00;
    exp_pcw = 1; exp_mreq = fs + 1; exp_mwe = 0; len = fs + 3;
    if (is_ill) begin
      len = fs + 2; exp_halt = 1; exp_trap = 1;
    end else if (is_alu) begin
      if (ovf) begin
        exp_halt = 1; exp_trap = 1;
      end else begin
        len = fs + 4; exp_wr = dst; exp_wc = fs + 3; exp_src = (dst == 3) ? 2'b01 : 2'b01;
      end
    end else if (is_ld) begin
      len = fs + ms + 5; exp_wr = dst; exp_wc = fs + ms + 4; exp_src = (dst == 3) ? 2'b01 : 2'b00;
      exp_mreq += ms + 1;
    end else if (is_st) begin
      len = fs + ms + 4; exp_mreq += ms + 1; exp_mwe = ms + 1;
    end else if (is_bnz) begin
      exp_pcw += int'(cnz);
    end else if (is_jal) begin
      exp_wr = 3; exp_wc = fs + 2; exp_src = 2'b00; exp_pcw = 2;
    end else if (is_li) begin
      if (dst != 2) begin
        exp_wr = dst; exp_wc = fs + 2; exp_src = (dst == 3) ? 2'b01 : 2'b10;
      end
    end else if (is_hlt) begin
      exp_halt = 1;
    end
    exp_a  = is_ld || is_st;
    exp_b  = is_alu ? word[9:8] : 2'b11;
    exp_op = is_alu ? word[15:12] : 4'h0;

    n_mreq = 0; n_mwe = 0; n_pcw = 0; n_wr = 0; n_halt = 0; bad_addr = 0; bad_pcsrc = 0;
    wr_idx = -1; wr_cyc = -1; wr_src = 2'b00;

    for (int c = 0; c < len; c++) begin
      @(negedge clock);
      instr = (c == fs) ? word : 16'($urandom);
      if (c < fs) mem_ready = 1'b0;
      else if (c == fs) mem_ready = 1'b1;
      else if ((is_ld || is_st) && c >= fs + 3) mem_ready = (c == fs + 3 + ms);
      else mem_ready = 1'($urandom);
      overflow = (c == fs + 2 && is_alu) ? ovf : 1'($urandom);
      comp_nz  = (c == fs + 2 && is_bnz) ? cnz : 1'($urandom);
      #1;
      if (c == 0) begin
        checks++;
        if (mem_req !== 1'b1 || addr_src !== 1'b0 || trap !== 1'b0) begin
          errors++;
          $display("FAIL fetch_entry op=%h: mem_req=%b addr_src=%b trap=%b, required 1 0 0", word, mem_req, addr_src, trap);
        end
      end
      if (mem_req) begin
        n_mreq++;
        if (addr_src !== (c > fs)) bad_addr++;
      end
      if (mem_we) n_mwe++;
      if (halted) n_halt++;
      if (pc_write) begin
        n_pcw++;
        if (pc_src !== ((c == fs) ? 2'b00 : 2'b01)) bad_pcsrc++;
      end
      wr = {ra_write, comp_write, shelley_write, mary_write};
      for (int k = 0; k < 4; k++) begin
        if (wr[k]) begin
          n_wr++; wr_idx = k; wr_cyc = c;
          wr_src = (k == 0) ? mary_src : (k == 1) ? shelley_src : (k == 3) ? {1'b0, ra_src} : 2'b00;
        end
      end
      if (c == fs + 1) begin
        checks++;
        if (immediate !== word[7:0]) begin
          errors++; $display("FAIL immediate op=%h: got %h, required %h", word, immediate, word[7:0]);
        end
      end
      if (c == fs + 2 && (is_alu || is_ld || is_st)) begin
        checks++;
        if (SrcA !== exp_a || SrcB !== exp_b || AluOp !== exp_op) begin
          errors++;
          $display("FAIL exec_fields op=%h: SrcA=%b SrcB=%b AluOp=%h, required %b %b %h", word, SrcA, SrcB, AluOp, exp_a, exp_b, exp_op);
        end
      end
    end

    checks++;
    if (n_mreq != exp_mreq || n_mwe != exp_mwe || bad_addr != 0) begin
      errors++;
      $display("FAIL mem_cycles op=%h: req=%0d we=%0d bad_addr=%0d, required %0d %0d 0", word, n_mreq, n_mwe, bad_addr, exp_mreq, exp_mwe);
    end
    checks++;
    if (n_pcw != exp_pcw || bad_pcsrc != 0) begin
      errors++;
      $display("FAIL pc_write op=%h: count=%0d bad_src=%0d, required %0d 0", word, n_pcw, bad_pcsrc, exp_pcw);
    end
    checks++;
    if (n_wr != ((exp_wr >= 0) ? 1 : 0) || n_halt != 0) begin
      errors++;
      $display("FAIL write_count op=%h: writes=%0d halted_cycles=%0d, required %0d 0", word, n_wr, n_halt, (exp_wr >= 0) ? 1 : 0);
    end
    if (exp_wr >= 0) begin
      checks++;
      if (wr_idx != exp_wr || wr_cyc != exp_wc) begin
        errors++;
        $display("FAIL write_target op=%h: reg=%0d cycle=%0d, required %0d %0d", word, wr_idx, wr_cyc, exp_wr, exp_wc);
      end
      if (exp_wr != 2) begin
        checks++;
        if (wr_src !== exp_src) begin
          errors++; $display("FAIL write_src op=%h: got %b, required %b", word, wr_src, exp_src);
        end
      end
    end

    if (exp_halt) begin
      for (int h = 0; h < 3; h++) begin
        @(negedge clock);
        instr = 16'($urandom); mem_ready = 1'($urandom);
        overflow = 1'($urandom); comp_nz = 1'($urandom);
        #1;
        checks++;
        if (halted !== 1'b1 || trap !== exp_trap || any_strobe() !== 1'b0) begin
          errors++;
          $display("FAIL halt_state op=%h: halted=%b trap=%b strobes=%b, required 1 %b 0", word, halted, trap, any_strobe(), exp_trap);
        end
      end
    end
  endtask

  task automatic test_alu_add();
    bit h;
    run_one(16'h0100, 0, 0, 1'b0, 1'b0, h);
    run_one(16'h3E00, 1, 0, 1'b0, 1'b0, h);
  endtask

  task automatic test_load_stall();
    bit h;
    run_one(16'h84FE, 0, 3, 1'b0, 1'b0, h);
    run_one(16'h9A10, 2, 1, 1'b0, 1'b0, h);
  endtask

  task automatic test_bnz();
    bit h;
    run_one(16'hA004, 0, 0, 1'b0, 1'b0, h);
    run_one(16'hA004, 0, 0, 1'b0, 1'b1, h);
  endtask

  task automatic test_jal_li();
    bit h;
    run_one(16'hB010, 0, 0, 1'b0, 1'b0, h);
    run_one(16'hC5AB, 0, 0, 1'b0, 1'b0, h);
    run_one(16'hC8FF, 1, 0, 1'b0, 1'b0, h);
    run_one(16'hCC80, 0, 0, 1'b0, 1'b0, h);
  endtask

  task automatic test_overflow();
    bit h;
    run_one(16'h0100, 0, 0, 1'b1, 1'b0, h);
    test_reset();
  endtask

  task automatic test_illegal();
    bit h;
    run_one(16'hD000, 0, 0, 1'b0, 1'b0, h);
    test_reset();
    run_one(16'hF000, 0, 0, 1'b0, 1'b0, h);
    test_reset();
  endtask

  task automatic test_reset_mid_store();
    bit h;
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      instr = (c == 0) ? 16'h9400 : 16'($urandom);
      mem_ready = (c == 0) ? 1'b1 : (c == 3) ? 1'b0 : 1'($urandom);
      overflow = 1'b0; comp_nz = 1'($urandom);
    end
    #1;
    checks++;
    if (mem_req !== 1'b1 || mem_we !== 1'b1 || addr_src !== 1'b1) begin
      errors++; $display("FAIL store_stall: req=%b we=%b addr_src=%b, required 1 1 1", mem_req, mem_we, addr_src);
    end
    @(negedge clock);
    reset = 1'b1; mem_ready = 1'b1;
    #1;
    checks++;
    if (any_strobe() !== 1'b0) begin
      errors++; $display("FAIL reset_in_mem: strobes=%b, required 0", any_strobe());
    end
    @(negedge clock);
    #1;
    checks++;
    if (mem_req !== 1'b0 || mem_we !== 1'b0 || trap !== 1'b0 || halted !== 1'b0) begin
      errors++;
      $display("FAIL reset_after_mem: req=%b we=%b trap=%b halted=%b, required 0 0 0 0", mem_req, mem_we, trap, halted);
    end
    @(posedge clock);
    #1;
    reset = 1'b0; mem_ready = 1'b0;
    run_one(16'h0600, 0, 0, 1'b0, 1'b0, h);
  endtask

  task automatic test_back_to_back();
    logic [15:0] w;
    int fs, ms;
    logic ovf, cnz;
    bit h;
    for (int i = 0; i < 60; i++) begin
      w   = 16'($urandom);
      fs  = $urandom_range(0, 2);
      ms  = $urandom_range(0, 3);
      ovf = ($urandom_range(0, 3) == 0);
      cnz = 1'($urandom);
      run_one(w, fs, ms, ovf, cnz, h);
      if (h) test_reset();
    end
  endtask

  initial begin
    test_reset();
    test_alu_add();
    test_load_stall();
    test_bnz();
    test_jal_li();
    test_overflow();
    test_illegal();
    test_reset_mid_store();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
